timer_dev: RTL

- Memory-mapped countdown timer peripheral on the CPU data bus: m_data_addr / m_data_wdata / m_data_byteen in, m_data_rdata out.
- Its irq output drives the CPU `interrupt` input.
- Provides the interrupt source for P7 exception/interrupt tests, so the bench no longer needs a hand-driven interrupt.
- Three word registers (CTRL, PRESET, COUNT) in a 16-byte window at BASE_ADDR.

---
 rtl/timer_dev.sv | 124 ++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers in a 16-byte window,
// a four-state sequencer, and a pending flag gated by IM onto irq.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  // state | meaning
  // IDLE  | waiting for EN
  // LOAD  | COUNT <= PRESET
  // CNT   | counting down; INT at zero, IDLE if EN drops
  // INT   | pend raised; reload (MODE 01) or disable (one-shot)
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_next;
  logic        en, im, pend;
  logic [1:0]  mode;
  logic [31:0] preset, count;

  logic        sel, wr, wr_ctrl, wr_preset;
  logic        do_load, do_dec, do_set, do_clr, do_en_clr;
  logic        unused_addr;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = sel && (|byteen);
  assign wr_ctrl     = wr && (addr[3:2] == 2'd0);
  assign wr_preset   = wr && (addr[3:2] == 2'd1);
  assign unused_addr = ^addr[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_set     = 1'b0;
    do_clr     = 1'b0;
    do_en_clr  = 1'b0;
    case (state)
      IDLE: if (en) state_next = LOAD;
      LOAD: begin
        do_load    = 1'b1;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count == 32'd0) begin
          do_set     = 1'b1;
          state_next = INT;
        end else begin
          do_dec = 1'b1;
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          do_clr     = 1'b1;
          state_next = LOAD;
        end else begin
          do_en_clr  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // CPU writes to CTRL override the sequencer's EN clear; a pend set beats any clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= 32'h0;
      count  <= 32'h0;
      pend   <= 1'b0;
    end else begin
      if (do_load)     count <= preset;
      else if (do_dec) count <= count - 32'd1;

      if (do_en_clr) en <= 1'b0;
      if (wr_ctrl && byteen[0]) {im, mode, en} <= wdata[3:0];

      if (wr_preset) preset <= merge(preset, wdata, byteen);

      if (do_set)                              pend <= 1'b1;
      else if (wr_ctrl || wr_preset || do_clr) pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr[3:2])
        2'd0:    rdata = {28'h0, im, mode, en};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'h0;
      endcase
    end
  end

  assign irq = pend & im;

endmodule
